// File: rtl/mem_if_pkg.sv
// Shared types for the HLS minimal-memory-interface RAM arbiter: FSM state encoding and size-to-mask helper.
package mem_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int MASK_MAX_W = 64;

  // Bit i is set when i < size, so any size at or above the data width yields all ones.
  function automatic logic [MASK_MAX_W-1:0] size_to_mask(input int unsigned size);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      m[i] = (i < size);
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin grant, combinational from req; last-served pointer advances only on an accepted grant.
// Zero latency; the caller's en says whether the grant is taken this cycle.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  // Reset as "ch1 served last" so the first contended grant goes to ch0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (en && (|gnt)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one single-port sync RAM between two HLS memory channels; DataRdy at grant+1+DELAY.
// No backpressure: masters hold requests until DataRdy; inputs are sampled only in IDLE.
module mem_port_arbiter
  import mem_if_pkg::*;
#(
  parameter  int ADDR_W      = 7,
  parameter  int DATA_W      = 8,
  parameter  int SIZE_W      = 4,
  parameter  int BASE_ADDR   = 0,
  parameter  int MEM_WORDS   = 32,
  parameter  int READ_DELAY  = 2,
  parameter  int WRITE_DELAY = 1,
  localparam int AW          = $clog2(MEM_WORDS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          oe_ram,
  input  logic [1:0]          we_ram,
  input  logic [2*ADDR_W-1:0] addr_ram,
  input  logic [2*DATA_W-1:0] Wdata_ram,
  input  logic [2*SIZE_W-1:0] data_ram_size,
  output logic [2*DATA_W-1:0] Rdata_ram,
  output logic [1:0]          DataRdy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err_oe_we
);

  localparam int CNT_W = 8;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_ld;
  logic              gch_q;
  logic              we_q;
  logic              cap_q;
  logic              err_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0] ch_addr  [2];
  logic [DATA_W-1:0] ch_wdata [2];
  logic [SIZE_W-1:0] ch_size  [2];
  logic [31:0]       ch_off   [2];
  logic [1:0]        eligible;
  logic [1:0]        gnt;
  logic              sel;

  // An address below BASE_ADDR wraps to a huge offset, so one compare covers both range ends.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      ch_addr[c]  = addr_ram[c*ADDR_W +: ADDR_W];
      ch_wdata[c] = Wdata_ram[c*DATA_W +: DATA_W];
      ch_size[c]  = data_ram_size[c*SIZE_W +: SIZE_W];
      ch_off[c]   = 32'(ch_addr[c]) - 32'(BASE_ADDR);
      eligible[c] = (oe_ram[c] ^ we_ram[c]) && (ch_off[c] < 32'(MEM_WORDS));
    end
  end

  rr_arbiter2 u_rr (
    .clock (clock),
    .reset (reset),
    .req   (eligible),
    .en    (state_q == ST_IDLE),
    .gnt   (gnt)
  );

  assign sel    = gnt[1];
  assign cnt_ld = we_q ? CNT_W'(WRITE_DELAY - 1) : CNT_W'(READ_DELAY - 1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gch_q   <= 1'b0;
      we_q    <= 1'b0;
      cap_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (|(oe_ram & we_ram)) begin
        err_q <= 1'b1;
      end
      cap_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            gch_q   <= sel;
            we_q    <= we_ram[sel];
            addr_q  <= ch_off[sel][AW-1:0];
            wdata_q <= ch_wdata[sel];
            wmask_q <= DATA_W'(size_to_mask(32'(ch_size[sel])));
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cnt_q   <= cnt_ld;
          cap_q   <= !we_q;
          state_q <= (cnt_ld == '0) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          // RAM data is valid only in the first WAIT cycle after the strobe.
          if (cap_q) begin
            rdata_q <= mem_rdata;
          end
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_oe_we = err_q;

  always_comb begin
    DataRdy   = '0;
    Rdata_ram = '0;
    if (state_q == ST_RESP) begin
      DataRdy[gch_q] = 1'b1;
      if (!we_q) begin
        if (gch_q) begin
          Rdata_ram[DATA_W +: DATA_W] = rdata_q;
        end else begin
          Rdata_ram[0 +: DATA_W] = rdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, randomized scoreboard run.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  oe_ram, we_ram;
  logic [13:0] addr_ram;
  logic [15:0] Wdata_ram;
  logic [7:0]  data_ram_size;
  logic [15:0] Rdata_ram, Rdata_ram5;
  logic [1:0]  DataRdy, DataRdy5;
  logic        mem_en, mem_we, mem_en5, mem_we5;
  logic [4:0]  mem_addr, mem_addr5;
  logic [7:0]  mem_wdata, mem_wmask, mem_rdata, mem_wdata5, mem_wmask5, mem_rdata5;
  logic        busy, err_oe_we, busy5, err_oe_we5;

  int nchk = 0;
  int nerr = 0;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset), .oe_ram(oe_ram), .we_ram(we_ram), .addr_ram(addr_ram),
    .Wdata_ram(Wdata_ram), .data_ram_size(data_ram_size), .Rdata_ram(Rdata_ram), .DataRdy(DataRdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy), .err_oe_we(err_oe_we)
  );

  mem_port_arbiter #(.READ_DELAY(5)) dut5 (
    .clock(clock), .reset(reset), .oe_ram(oe_ram), .we_ram(we_ram), .addr_ram(addr_ram),
    .Wdata_ram(Wdata_ram), .data_ram_size(data_ram_size), .Rdata_ram(Rdata_ram5), .DataRdy(DataRdy5),
    .mem_en(mem_en5), .mem_we(mem_we5), .mem_addr(mem_addr5), .mem_wdata(mem_wdata5),
    .mem_wmask(mem_wmask5), .mem_rdata(mem_rdata5), .busy(busy5), .err_oe_we(err_oe_we5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model for the main DUT; load_mem copies seed_mem in one cycle.
  logic [7:0] ram      [32];
  logic [7:0] seed_mem [32];
  logic       load_mem;

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 32; i++) ram[i] <= seed_mem[i];
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // The slow-read instance sees a fixed pattern: data = address ^ 8'h55.
  always @(posedge clock) begin
    if (mem_en5 && !mem_we5) mem_rdata5 <= {3'b000, mem_addr5} ^ 8'h55;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int c, input logic oe, input logic we, input logic [6:0] a,
                       input logic [7:0] wd, input logic [3:0] sz);
    oe_ram[c]               = oe;
    we_ram[c]               = we;
    addr_ram[c*7 +: 7]      = a;
    Wdata_ram[c*8 +: 8]     = wd;
    data_ram_size[c*4 +: 4] = sz;
  endtask

  typedef struct {
    int         ch;
    logic       oe;
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [3:0] size;
    int         exp_lat;    // cycles from request to DataRdy, -1 = never
    logic [7:0] exp_rdata;
    logic [7:0] exp_mask;
    logic [4:0] exp_maddr;
    logic       exp_en;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v, input string nm);
    int lat, en_k, en_cnt, oth, leak;
    logic [7:0] rd, mk;
    logic [4:0] ma;
    logic       wev;
    lat = -1; en_k = -1; en_cnt = 0; oth = 0; leak = 0; rd = 0; mk = 0; ma = 0; wev = 0;
    @(posedge clock); #1;
    drive(v.ch, v.oe, v.we, v.addr, v.wdata, v.size);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (mem_en) begin
        en_cnt++;
        if (en_k < 0) begin en_k = k; ma = mem_addr; mk = mem_wmask; wev = mem_we; end
      end
      if (DataRdy[v.ch] && lat < 0) begin lat = k; rd = Rdata_ram[v.ch*8 +: 8]; end
      if (DataRdy[1-v.ch]) oth++;
      if (!DataRdy[v.ch] && Rdata_ram != 16'h0) leak++;
      if (DataRdy[v.ch] && Rdata_ram[(1-v.ch)*8 +: 8] != 8'h0) leak++;
      @(posedge clock); #1;
      if (lat >= 0) drive(v.ch, 0, 0, 0, 0, 0);
    end
    drive(v.ch, 0, 0, 0, 0, 0);
    chk({nm, "_lat"}, lat, v.exp_lat);
    chk({nm, "_en_cycle"}, en_k, v.exp_en ? 1 : -1);
    chk({nm, "_en_count"}, en_cnt, v.exp_en ? 1 : 0);
    if (v.exp_en) begin
      chk({nm, "_maddr"}, ma, v.exp_maddr);
      chk({nm, "_mwe"}, wev, v.we);
      if (v.we) chk({nm, "_mask"}, mk, v.exp_mask);
    end
    if (!v.we && v.exp_lat >= 0) chk({nm, "_rdata"}, rd, v.exp_rdata);
    chk({nm, "_other_rdy"}, oth, 0);
    chk({nm, "_rdata_leak"}, leak, 0);
  endtask

  // Randomized phase state and reference model.
  logic [7:0] model_mem [32];
  logic       pend [2], done [2], r_we [2];
  logic [6:0] r_addr [2];
  logic [7:0] r_wd [2];
  logic [3:0] r_sz [2];
  int         age [2];

  function automatic logic [7:0] ref_mask(input logic [3:0] sz);
    return (sz >= 4'd8) ? 8'hFF : 8'((1 << sz) - 1);
  endfunction

  initial begin
    int lat1, lat5, ev, n_done, n_spur, n_leak, n_starve;
    logic [7:0] rd1, rd5, m;
    int ev_k [4], ev_c [4], ev_d [4];

    reset = 1'b0; load_mem = 1'b0;
    oe_ram = '0; we_ram = '0; addr_ram = '0; Wdata_ram = '0; data_ram_size = '0;
    for (int i = 0; i < 32; i++) seed_mem[i] = 8'h00;
    seed_mem[5] = 8'hA7;

    vecs[0]  = '{0, 1'b1, 1'b0, 7'd5,   8'h00, 4'd8,  3,  8'hA7, 8'h00, 5'd5,  1'b1};
    vecs[1]  = '{1, 1'b0, 1'b1, 7'd3,   8'h3C, 4'd8,  2,  8'h00, 8'hFF, 5'd3,  1'b1};
    vecs[2]  = '{1, 1'b1, 1'b0, 7'd3,   8'h00, 4'd8,  3,  8'h3C, 8'h00, 5'd3,  1'b1};
    vecs[3]  = '{0, 1'b0, 1'b1, 7'd3,   8'hFF, 4'd4,  2,  8'h00, 8'h0F, 5'd3,  1'b1};
    vecs[4]  = '{0, 1'b1, 1'b0, 7'd3,   8'h00, 4'd8,  3,  8'h3F, 8'h00, 5'd3,  1'b1};
    vecs[5]  = '{1, 1'b0, 1'b1, 7'd3,   8'h00, 4'd0,  2,  8'h00, 8'h00, 5'd3,  1'b1};
    vecs[6]  = '{1, 1'b1, 1'b0, 7'd3,   8'h00, 4'd8,  3,  8'h3F, 8'h00, 5'd3,  1'b1};
    vecs[7]  = '{1, 1'b0, 1'b1, 7'd31,  8'h5A, 4'd12, 2,  8'h00, 8'hFF, 5'd31, 1'b1};
    vecs[8]  = '{0, 1'b1, 1'b0, 7'd31,  8'h00, 4'd8,  3,  8'h5A, 8'h00, 5'd31, 1'b1};
    vecs[9]  = '{0, 1'b1, 1'b0, 7'd40,  8'h00, 4'd8,  -1, 8'h00, 8'h00, 5'd0,  1'b0};
    vecs[10] = '{1, 1'b0, 1'b1, 7'd32,  8'h11, 4'd8,  -1, 8'h00, 8'h00, 5'd0,  1'b0};
    vecs[11] = '{1, 1'b0, 1'b1, 7'd0,   8'hFF, 4'd7,  2,  8'h00, 8'h7F, 5'd0,  1'b1};
    vecs[12] = '{0, 1'b1, 1'b0, 7'd0,   8'h00, 4'd8,  3,  8'h7F, 8'h00, 5'd0,  1'b1};
    vecs[13] = '{0, 1'b1, 1'b0, 7'd127, 8'h00, 4'd8,  -1, 8'h00, 8'h00, 5'd0,  1'b0};

    // Reset state
    repeat (2) @(posedge clock);
    #1 load_mem = 1'b1;
    @(posedge clock); #1 load_mem = 1'b0;
    @(negedge clock);
    chk("rst_datardy", DataRdy, 0);
    chk("rst_rdata", Rdata_ram, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_oe_we, 0);
    @(posedge clock); #1 reset = 1'b1;

    // Default and READ_DELAY=5 instances on the same read
    lat1 = -1; lat5 = -1; rd1 = 0; rd5 = 0;
    @(posedge clock); #1 drive(0, 1, 0, 5, 0, 8);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (DataRdy[0] && lat1 < 0) begin lat1 = k; rd1 = Rdata_ram[7:0]; end
      if (DataRdy5[0] && lat5 < 0) begin lat5 = k; rd5 = Rdata_ram5[7:0]; end
      @(posedge clock); #1;
      if (lat5 >= 0) drive(0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("rd2_lat", lat1, 3);
    chk("rd2_rdata", rd1, 8'hA7);
    chk("rd5_lat", lat5, 6);
    chk("rd5_rdata", rd5, 8'h50);
    repeat (4) @(posedge clock);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Inputs changed mid-transaction are ignored
    lat1 = -1; rd1 = 0; ev = 0;
    @(posedge clock); #1 drive(0, 1, 0, 5, 0, 8);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (mem_we) ev++;
      if (DataRdy[0] && lat1 < 0) begin lat1 = k; rd1 = Rdata_ram[7:0]; end
      @(posedge clock); #1;
      if (k == 0) drive(0, 0, 1, 7'd0, 8'h11, 4'd8);
      if (lat1 >= 0) drive(0, 0, 0, 0, 0, 0);
    end
    chk("hold_lat", lat1, 3);
    chk("hold_rdata", rd1, 8'hA7);
    chk("hold_no_write", ev, 0);

    // oe&we on ch0 flags an error and ch1 is still served
    lat1 = -1; lat5 = -1; rd1 = 0;
    @(posedge clock); #1 drive(0, 1, 1, 5, 8'hEE, 8); drive(1, 1, 0, 31, 0, 8);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 1) chk("err_set", err_oe_we, 1);
      if (DataRdy[1] && lat1 < 0) begin lat1 = k; rd1 = Rdata_ram[15:8]; end
      if (DataRdy[0]) lat5 = k;
      @(posedge clock); #1;
      if (lat1 >= 0) drive(1, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("err_ch1_lat", lat1, 3);
    chk("err_ch1_rdata", rd1, 8'h5A);
    chk("err_ch0_never", lat5, -1);
    chk("err_sticky", err_oe_we, 1);

    // Reset while a read is in WAIT
    @(posedge clock); #1 drive(0, 1, 0, 5, 0, 8);
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock); chk("rstmid_en", mem_en, 1);
    @(posedge clock); #1 reset = 1'b0; drive(0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("rstmid_datardy", DataRdy, 0);
    chk("rstmid_rdata", Rdata_ram, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_mem_en", mem_en, 0);
    chk("rstmid_err", err_oe_we, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    reset = 1'b1;
    ev = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (DataRdy != 2'b00) ev++;
    end
    chk("rstmid_no_rdy", ev, 0);

    // Contention: both channels read continuously, grants alternate from ch0
    for (int i = 0; i < 4; i++) begin ev_k[i] = -1; ev_c[i] = -1; ev_d[i] = -1; end
    ev = 0;
    @(posedge clock); #1 drive(0, 1, 0, 5, 0, 8); drive(1, 1, 0, 31, 0, 8);
    for (int k = 0; k < 18; k++) begin
      @(negedge clock);
      if (DataRdy != 2'b00) begin
        if (ev < 4) begin
          ev_k[ev] = k;
          ev_c[ev] = DataRdy[1] ? 1 : 0;
          ev_d[ev] = DataRdy[1] ? int'(Rdata_ram[15:8]) : int'(Rdata_ram[7:0]);
        end
        ev++;
      end
      @(posedge clock); #1;
    end
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    chk("cont_count", ev, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont%0d_cycle", i), ev_k[i], 3 + 4*i);
      chk($sformatf("cont%0d_ch", i), ev_c[i], i % 2);
      chk($sformatf("cont%0d_rdata", i), ev_d[i], (i % 2 == 1) ? 8'h5A : 8'hA7);
    end
    repeat (8) @(posedge clock);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 32; i++) begin
      seed_mem[i]  = 8'($urandom);
      model_mem[i] = seed_mem[i];
    end
    #1 load_mem = 1'b1;
    @(posedge clock); #1 load_mem = 1'b0;
    for (int c = 0; c < 2; c++) begin pend[c] = 0; done[c] = 0; age[c] = 0; end
    n_done = 0; n_spur = 0; n_leak = 0; n_starve = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clock); #1;
      for (int c = 0; c < 2; c++) begin
        if (pend[c] && done[c]) begin pend[c] = 0; drive(c, 0, 0, 0, 0, 0); end
        if (!pend[c] && $urandom_range(2) == 0) begin
          pend[c] = 1; done[c] = 0; age[c] = 0;
          r_we[c]   = 1'($urandom_range(1));
          r_addr[c] = ($urandom_range(9) == 0) ? 7'($urandom_range(127, 32)) : 7'($urandom_range(31));
          r_wd[c]   = 8'($urandom);
          r_sz[c]   = 4'($urandom_range(12));
          drive(c, !r_we[c], r_we[c], r_addr[c], r_wd[c], r_sz[c]);
        end
      end
      @(negedge clock);
      for (int c = 0; c < 2; c++) begin
        if (!DataRdy[c] && Rdata_ram[c*8 +: 8] != 8'h0) n_leak++;
        if (pend[c] && !done[c]) begin
          if (DataRdy[c]) begin
            chk($sformatf("rnd_inrange_ch%0d", c), int'(r_addr[c] < 7'd32), 1);
            if (r_we[c]) begin
              m = ref_mask(r_sz[c]);
              model_mem[r_addr[c][4:0]] = (model_mem[r_addr[c][4:0]] & ~m) | (r_wd[c] & m);
            end else begin
              chk($sformatf("rnd_rdata_ch%0d_a%0d", c, r_addr[c]), Rdata_ram[c*8 +: 8],
                  model_mem[r_addr[c][4:0]]);
            end
            done[c] = 1; n_done++;
          end else if (r_addr[c] >= 7'd32 && age[c] >= 8) begin
            done[c] = 1;
          end else if (r_addr[c] < 7'd32 && age[c] > 12) begin
            n_starve++; done[c] = 1;
          end
          age[c]++;
        end else if (DataRdy[c]) begin
          n_spur++;
        end
      end
    end
    chk("rnd_spurious_rdy", n_spur, 0);
    chk("rnd_rdata_leak", n_leak, 0);
    chk("rnd_starved", n_starve, 0);
    chk("rnd_activity", int'(n_done > 200), 1);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
